// File: rtl/axonerve_kvs_requester.sv
// Host-side command initiator for the Axonerve KVS kernel: issues requests as one-cycle
// command pulses, tags them with their opcode and returns in-order buffered responses.
module axonerve_kvs_requester #(
  parameter int MAX_OUT = 8,
  parameter int TAG_W   = 3
) (
  input  logic             I_CLK,
  input  logic             I_RST,
  input  logic             I_REQ_VALID,
  output logic             O_REQ_READY,
  input  logic [TAG_W-1:0] I_REQ_OP,
  input  logic [127:0]     I_REQ_KEY,
  input  logic [127:0]     I_REQ_MSK,
  input  logic [6:0]       I_REQ_PRI,
  input  logic [31:0]      I_REQ_VALUE,
  input  logic             I_FLUSH,
  output logic             O_FLUSH_DONE,
  output logic             O_CMD_VALID,
  output logic             O_CMD_ERASE,
  output logic             O_CMD_WRITE,
  output logic             O_CMD_READ,
  output logic             O_CMD_SEARCH,
  output logic             O_CMD_UPDATE,
  output logic [127:0]     O_KEY_DAT,
  output logic [127:0]     O_EKEY_MSK,
  output logic [6:0]       O_KEY_PRI,
  output logic [31:0]      O_KEY_VALUE,
  input  logic             I_K_READY,
  input  logic             I_K_WAIT,
  input  logic             I_K_CMD_FULL,
  input  logic             I_K_ACK,
  input  logic             I_K_SHIT,
  input  logic             I_K_MHIT,
  input  logic             I_K_ENT_ERR,
  input  logic [31:0]      I_K_VALUE,
  input  logic [15:0]      I_K_ENT_ADDR,
  output logic             O_RSP_VALID,
  input  logic             I_RSP_READY,
  output logic [TAG_W-1:0] O_RSP_OP,
  output logic             O_RSP_HIT,
  output logic             O_RSP_MHIT,
  output logic             O_RSP_ERR,
  output logic [31:0]      O_RSP_VALUE,
  output logic [15:0]      O_RSP_ADDR,
  output logic [6:0]       O_INFLIGHT,
  output logic             O_PROTO_ERR
);
  localparam int AW = $clog2(MAX_OUT);
  localparam int RW = TAG_W + 3 + 32 + 16;
  localparam logic [6:0]  MAX_INF = MAX_OUT[6:0];
  localparam logic [AW:0] DEPTH   = MAX_OUT[AW:0];

  localparam logic [TAG_W-1:0] OP_SEARCH = 0;
  localparam logic [TAG_W-1:0] OP_WRITE  = 1;
  localparam logic [TAG_W-1:0] OP_ERASE  = 2;
  localparam logic [TAG_W-1:0] OP_UPDATE = 3;
  localparam logic [TAG_W-1:0] OP_READ   = 4;

  typedef enum logic [1:0] {WAIT_RDY, RUN, DRAIN} state_t;
  state_t state;

  logic [6:0]       inflight, inflight_nxt;
  logic             accept, rsp_pop, tag_pop, rsp_push, legal_op;
  logic [TAG_W-1:0] tag_mem [MAX_OUT];
  logic [RW-1:0]    rsp_mem [MAX_OUT];
  logic [AW-1:0]    tag_wp, tag_rp, rsp_wp, rsp_rp;
  logic [AW:0]      tag_cnt, rsp_cnt;
  logic [RW-1:0]    rsp_head;

  assign O_REQ_READY = (state == RUN) && I_K_READY && !I_K_WAIT && !I_K_CMD_FULL &&
                       (inflight < MAX_INF) && !I_FLUSH;
  assign accept   = I_REQ_VALID && O_REQ_READY;
  assign legal_op = (I_REQ_OP <= OP_READ);
  assign rsp_pop  = O_RSP_VALID && I_RSP_READY;
  assign tag_pop  = I_K_ACK && (tag_cnt != '0);
  // inflight bounds the response FIFO occupancy, so the full guard is only a safety net
  assign rsp_push = tag_pop && ((rsp_cnt != DEPTH) || rsp_pop);

  assign O_INFLIGHT  = inflight;
  assign O_RSP_VALID = (rsp_cnt != '0);
  assign rsp_head    = O_RSP_VALID ? rsp_mem[rsp_rp] : '0;
  assign {O_RSP_OP, O_RSP_HIT, O_RSP_MHIT, O_RSP_ERR, O_RSP_VALUE, O_RSP_ADDR} = rsp_head;

  always_comb begin
    inflight_nxt = inflight;
    if (accept && !rsp_pop)      inflight_nxt = inflight + 7'd1;
    else if (!accept && rsp_pop) inflight_nxt = inflight - 7'd1;
  end

  always_ff @(posedge I_CLK) begin
    if (accept)   tag_mem[tag_wp] <= I_REQ_OP;
    if (rsp_push) rsp_mem[rsp_wp] <= {tag_mem[tag_rp], I_K_SHIT, I_K_MHIT, I_K_ENT_ERR,
                                      I_K_VALUE, I_K_ENT_ADDR};
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state        <= WAIT_RDY;
      inflight     <= '0;
      tag_wp       <= '0;
      tag_rp       <= '0;
      tag_cnt      <= '0;
      rsp_wp       <= '0;
      rsp_rp       <= '0;
      rsp_cnt      <= '0;
      O_FLUSH_DONE <= 1'b0;
      O_PROTO_ERR  <= 1'b0;
      O_CMD_VALID  <= 1'b0;
      O_CMD_ERASE  <= 1'b0;
      O_CMD_WRITE  <= 1'b0;
      O_CMD_READ   <= 1'b0;
      O_CMD_SEARCH <= 1'b0;
      O_CMD_UPDATE <= 1'b0;
      O_KEY_DAT    <= '0;
      O_EKEY_MSK   <= '0;
      O_KEY_PRI    <= '0;
      O_KEY_VALUE  <= '0;
    end else begin
      O_FLUSH_DONE <= 1'b0;
      if (!I_K_READY) begin
        state <= WAIT_RDY;
      end else begin
        case (state)
          WAIT_RDY: state <= RUN;
          RUN:      if (I_FLUSH) state <= DRAIN;
          DRAIN: begin
            if (inflight_nxt == '0) begin
              state        <= RUN;
              O_FLUSH_DONE <= 1'b1;
            end
          end
          default:  state <= WAIT_RDY;
        endcase
      end

      inflight <= inflight_nxt;

      // Illegal opcodes go out as a harmless all-zero SEARCH but keep their own tag
      O_CMD_VALID  <= accept;
      O_CMD_SEARCH <= accept && ((I_REQ_OP == OP_SEARCH) || !legal_op);
      O_CMD_WRITE  <= accept && (I_REQ_OP == OP_WRITE);
      O_CMD_ERASE  <= accept && (I_REQ_OP == OP_ERASE);
      O_CMD_UPDATE <= accept && (I_REQ_OP == OP_UPDATE);
      O_CMD_READ   <= accept && (I_REQ_OP == OP_READ);
      if (accept) begin
        O_KEY_DAT   <= legal_op ? I_REQ_KEY : '0;
        O_EKEY_MSK  <= legal_op ? I_REQ_MSK : '0;
        O_KEY_PRI   <= I_REQ_PRI;
        O_KEY_VALUE <= I_REQ_VALUE;
        tag_wp      <= tag_wp + AW'(1);
      end
      if (tag_pop)  tag_rp <= tag_rp + AW'(1);
      tag_cnt <= tag_cnt + {{AW{1'b0}}, accept} - {{AW{1'b0}}, tag_pop};

      if (rsp_push) rsp_wp <= rsp_wp + AW'(1);
      if (rsp_pop)  rsp_rp <= rsp_rp + AW'(1);
      rsp_cnt <= rsp_cnt + {{AW{1'b0}}, rsp_push} - {{AW{1'b0}}, rsp_pop};

      if ((I_K_ACK && (tag_cnt == '0)) || (tag_pop && !rsp_push)) O_PROTO_ERR <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axonerve_kvs_requester.sv
// Directed bench for axonerve_kvs_requester; a queue-based reference model is compared
// against the DUT on every falling edge, plus literal expectations per scenario.
module tb_axonerve_kvs_requester;
  logic         I_CLK = 1'b0;
  logic         I_RST, I_REQ_VALID, O_REQ_READY, I_FLUSH, O_FLUSH_DONE;
  logic [2:0]   I_REQ_OP;
  logic [127:0] I_REQ_KEY, I_REQ_MSK;
  logic [6:0]   I_REQ_PRI;
  logic [31:0]  I_REQ_VALUE;
  logic         O_CMD_VALID, O_CMD_ERASE, O_CMD_WRITE, O_CMD_READ, O_CMD_SEARCH, O_CMD_UPDATE;
  logic [127:0] O_KEY_DAT, O_EKEY_MSK;
  logic [6:0]   O_KEY_PRI;
  logic [31:0]  O_KEY_VALUE;
  logic         I_K_READY, I_K_WAIT, I_K_CMD_FULL, I_K_ACK, I_K_SHIT, I_K_MHIT, I_K_ENT_ERR;
  logic [31:0]  I_K_VALUE;
  logic [15:0]  I_K_ENT_ADDR;
  logic         O_RSP_VALID, I_RSP_READY, O_RSP_HIT, O_RSP_MHIT, O_RSP_ERR, O_PROTO_ERR;
  logic [2:0]   O_RSP_OP;
  logic [31:0]  O_RSP_VALUE;
  logic [15:0]  O_RSP_ADDR;
  logic [6:0]   O_INFLIGHT;

  int checks = 0;
  int errors = 0;

  always #5 I_CLK = ~I_CLK;

  axonerve_kvs_requester #(.MAX_OUT(8), .TAG_W(3)) dut (
    .I_CLK(I_CLK), .I_RST(I_RST), .I_REQ_VALID(I_REQ_VALID), .O_REQ_READY(O_REQ_READY),
    .I_REQ_OP(I_REQ_OP), .I_REQ_KEY(I_REQ_KEY), .I_REQ_MSK(I_REQ_MSK), .I_REQ_PRI(I_REQ_PRI),
    .I_REQ_VALUE(I_REQ_VALUE), .I_FLUSH(I_FLUSH), .O_FLUSH_DONE(O_FLUSH_DONE),
    .O_CMD_VALID(O_CMD_VALID), .O_CMD_ERASE(O_CMD_ERASE), .O_CMD_WRITE(O_CMD_WRITE),
    .O_CMD_READ(O_CMD_READ), .O_CMD_SEARCH(O_CMD_SEARCH), .O_CMD_UPDATE(O_CMD_UPDATE),
    .O_KEY_DAT(O_KEY_DAT), .O_EKEY_MSK(O_EKEY_MSK), .O_KEY_PRI(O_KEY_PRI), .O_KEY_VALUE(O_KEY_VALUE),
    .I_K_READY(I_K_READY), .I_K_WAIT(I_K_WAIT), .I_K_CMD_FULL(I_K_CMD_FULL), .I_K_ACK(I_K_ACK),
    .I_K_SHIT(I_K_SHIT), .I_K_MHIT(I_K_MHIT), .I_K_ENT_ERR(I_K_ENT_ERR), .I_K_VALUE(I_K_VALUE),
    .I_K_ENT_ADDR(I_K_ENT_ADDR), .O_RSP_VALID(O_RSP_VALID), .I_RSP_READY(I_RSP_READY),
    .O_RSP_OP(O_RSP_OP), .O_RSP_HIT(O_RSP_HIT), .O_RSP_MHIT(O_RSP_MHIT), .O_RSP_ERR(O_RSP_ERR),
    .O_RSP_VALUE(O_RSP_VALUE), .O_RSP_ADDR(O_RSP_ADDR), .O_INFLIGHT(O_INFLIGHT),
    .O_PROTO_ERR(O_PROTO_ERR)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected outputs for the current cycle
  typedef struct packed {
    logic [2:0] op; logic hit; logic mhit; logic err; logic [31:0] value; logic [15:0] addr;
  } rsp_t;
  rsp_t       rsp_q[$];
  logic [2:0] tag_q[$];
  int         m_inflight, m_mode;  // mode: 0 waiting for kernel, 1 running, 2 draining
  bit         m_cmd_valid, m_flush_done, m_proto_err;
  logic [4:0] m_flags;             // {erase, write, read, search, update}
  logic [127:0] m_key, m_msk;
  logic [6:0]   m_pri;
  logic [31:0]  m_val;

  function automatic logic [4:0] flags_of(input logic [2:0] op);
    case (op)
      3'd1:    return 5'b01000;
      3'd2:    return 5'b10000;
      3'd3:    return 5'b00001;
      3'd4:    return 5'b00100;
      default: return 5'b00010;
    endcase
  endfunction

  initial begin
    bit   ready, accept, pop;
    rsp_t r;
    m_mode = 0; m_inflight = 0; m_cmd_valid = 0; m_flush_done = 0; m_proto_err = 0;
    m_flags = '0; m_key = '0; m_msk = '0; m_pri = '0; m_val = '0;
    @(posedge I_CLK);
    forever begin
      @(negedge I_CLK);
      ready = (m_mode == 1) && I_K_READY && !I_K_WAIT && !I_K_CMD_FULL &&
              (m_inflight < 8) && !I_FLUSH;
      chk("req_ready", O_REQ_READY, ready);
      chk("cmd_valid", O_CMD_VALID, m_cmd_valid);
      if (m_cmd_valid) begin
        chk("cmd_flags", {O_CMD_ERASE, O_CMD_WRITE, O_CMD_READ, O_CMD_SEARCH, O_CMD_UPDATE}, m_flags);
        chk("cmd_key", O_KEY_DAT, m_key);
        chk("cmd_msk", O_EKEY_MSK, m_msk);
        chk("cmd_pri_value", {O_KEY_PRI, O_KEY_VALUE}, {m_pri, m_val});
      end else begin
        chk("cmd_flags_idle", {O_CMD_ERASE, O_CMD_WRITE, O_CMD_READ, O_CMD_SEARCH, O_CMD_UPDATE}, 5'd0);
      end
      chk("rsp_valid", O_RSP_VALID, rsp_q.size() != 0);
      if (rsp_q.size() != 0)
        chk("rsp_head", {O_RSP_OP, O_RSP_HIT, O_RSP_MHIT, O_RSP_ERR, O_RSP_VALUE, O_RSP_ADDR}, rsp_q[0]);
      chk("inflight", O_INFLIGHT, m_inflight[6:0]);
      chk("flush_done", O_FLUSH_DONE, m_flush_done);
      chk("proto_err", O_PROTO_ERR, m_proto_err);

      if (I_RST) begin
        rsp_q.delete(); tag_q.delete();
        m_mode = 0; m_inflight = 0; m_cmd_valid = 0; m_flush_done = 0; m_proto_err = 0;
      end else begin
        accept = I_REQ_VALID && ready;
        pop    = (rsp_q.size() != 0) && I_RSP_READY;
        if (pop) void'(rsp_q.pop_front());
        if (I_K_ACK) begin
          if (tag_q.size() == 0) m_proto_err = 1;
          else begin
            r.op = tag_q.pop_front(); r.hit = I_K_SHIT; r.mhit = I_K_MHIT; r.err = I_K_ENT_ERR;
            r.value = I_K_VALUE; r.addr = I_K_ENT_ADDR;
            rsp_q.push_back(r);
          end
        end
        m_cmd_valid = accept;
        if (accept) begin
          tag_q.push_back(I_REQ_OP);
          m_flags = flags_of(I_REQ_OP);
          m_key   = (I_REQ_OP <= 3'd4) ? I_REQ_KEY : '0;
          m_msk   = (I_REQ_OP <= 3'd4) ? I_REQ_MSK : '0;
          m_pri   = I_REQ_PRI;
          m_val   = I_REQ_VALUE;
        end
        m_inflight = m_inflight + int'(accept) - int'(pop);
        m_flush_done = 0;
        if (!I_K_READY) m_mode = 0;
        else if (m_mode == 0) m_mode = 1;
        else if (m_mode == 1 && I_FLUSH) m_mode = 2;
        else if (m_mode == 2 && m_inflight == 0) begin
          m_mode = 1;
          m_flush_done = 1;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge I_CLK);
      #1;
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [127:0] key);
    bit hs = 0;
    I_REQ_VALID = 1'b1; I_REQ_OP = op; I_REQ_KEY = key; I_REQ_MSK = ~key;
    I_REQ_PRI = key[6:0] ^ 7'h3f; I_REQ_VALUE = key[31:0] + 32'h1000;
    for (int t = 0; t < 100 && !hs; t++) begin
      #1 hs = O_REQ_READY;
      @(posedge I_CLK);
      #1;
    end
    I_REQ_VALID = 1'b0;
    if (!hs) begin
      checks++; errors++;
      $display("FAIL send_timeout: op %0d not accepted within 100 cycles", op);
    end
  endtask

  task automatic ack(input logic shit, input logic mhit, input logic err,
                     input logic [31:0] val, input logic [15:0] addr);
    I_K_ACK = 1'b1; I_K_SHIT = shit; I_K_MHIT = mhit; I_K_ENT_ERR = err;
    I_K_VALUE = val; I_K_ENT_ADDR = addr;
    cyc(1);
    I_K_ACK = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    I_RST = 1; I_REQ_VALID = 0; I_REQ_OP = 0; I_REQ_KEY = 0; I_REQ_MSK = 0; I_REQ_PRI = 0;
    I_REQ_VALUE = 0; I_FLUSH = 0; I_K_READY = 0; I_K_WAIT = 0; I_K_CMD_FULL = 0; I_K_ACK = 0;
    I_K_SHIT = 0; I_K_MHIT = 0; I_K_ENT_ERR = 0; I_K_VALUE = 0; I_K_ENT_ADDR = 0; I_RSP_READY = 1;
    cyc(3);
    I_RST = 0;
    cyc(2);
    chk("t1_reset_ready", O_REQ_READY, 1'b0);
    chk("t1_reset_inflight", O_INFLIGHT, 7'd0);
    I_K_READY = 1;
    #1;
    chk("t1_ready_same_cycle", O_REQ_READY, 1'b0);
    cyc(1);
    chk("t1_ready_next_cycle", O_REQ_READY, 1'b1);
    send(3'd1, 128'h1);
    chk("t1_cmd_write", {O_CMD_VALID, O_CMD_WRITE}, 2'b11);
    chk("t1_key", O_KEY_DAT, 128'h1);
    cyc(1);
    chk("t1_cmd_one_cycle", O_CMD_VALID, 1'b0);
    ack(1, 0, 0, 32'hCAFE, 16'h0010);
    cyc(2);

    // 8 searches with the response side stalled
    I_RSP_READY = 0;
    for (int i = 0; i < 8; i++) send(3'd0, 128'h200 + 128'(i));
    chk("t2_inflight_full", O_INFLIGHT, 7'd8);
    chk("t2_ready_full", O_REQ_READY, 1'b0);
    for (int i = 0; i < 8; i++) ack(i[0], 0, 0, 32'h100 + i, 16'(i));
    I_REQ_VALID = 1; I_REQ_OP = 3'd0;
    cyc(3);
    chk("t2_still_blocked", O_REQ_READY, 1'b0);
    I_REQ_VALID = 0;
    chk("t2_rsp_queued", {O_RSP_VALID, O_INFLIGHT}, {1'b1, 7'd8});
    I_RSP_READY = 1;
    cyc(8);
    chk("t2_drained", {O_RSP_VALID, O_INFLIGHT}, {1'b0, 7'd0});

    // Ordering and illegal opcode
    I_RSP_READY = 0;
    send(3'd0, 128'hA); send(3'd2, 128'hB); send(3'd3, 128'hC);
    send(3'd6, 128'hFF);
    chk("t3_illegal_search", {O_CMD_VALID, O_CMD_SEARCH, O_CMD_WRITE}, 3'b110);
    chk("t3_illegal_key", O_KEY_DAT, 128'h0);
    ack(1, 0, 0, 32'h11, 16'h1); ack(0, 0, 0, 32'h22, 16'h2);
    ack(1, 1, 0, 32'h33, 16'h3); ack(0, 0, 1, 32'h44, 16'h4);
    chk("t3_head0", {O_RSP_OP, O_RSP_HIT}, 4'b0001);
    I_RSP_READY = 1; cyc(1); I_RSP_READY = 0;
    chk("t3_head1", {O_RSP_OP, O_RSP_HIT}, 4'b0100);
    I_RSP_READY = 1; cyc(1); I_RSP_READY = 0;
    chk("t3_head2", {O_RSP_OP, O_RSP_HIT, O_RSP_VALUE}, {4'b0111, 32'h33});
    I_RSP_READY = 1; cyc(1); I_RSP_READY = 0;
    chk("t3_head3", {O_RSP_OP, O_RSP_ERR}, 4'b1101);
    I_RSP_READY = 1;
    cyc(2);

    // Kernel back-pressure
    I_K_CMD_FULL = 1;
    fork
      send(3'd4, 128'h44);
      begin cyc(3); chk("t4_no_cmd_full", O_CMD_VALID, 1'b0); I_K_CMD_FULL = 0; end
    join
    fork
      begin send(3'd0, 128'h50); send(3'd1, 128'h51); send(3'd2, 128'h52); send(3'd3, 128'h53); end
      begin cyc(1); I_K_WAIT = 1; cyc(3); chk("t4_no_cmd_wait", O_CMD_VALID, 1'b0); I_K_WAIT = 0; end
    join
    for (int i = 0; i < 5; i++) ack(0, i[1], 0, 32'h400 + i, 16'h40 + 16'(i));
    cyc(2);
    chk("t4_all_returned", {O_RSP_VALID, O_INFLIGHT}, {1'b0, 7'd0});
    send(3'd1, 128'h60);
    I_K_READY = 0;
    cyc(2);
    chk("t4_kernel_down", {O_REQ_READY, O_INFLIGHT}, {1'b0, 7'd1});
    I_K_READY = 1;
    ack(0, 0, 0, 32'h60, 16'h60);
    send(3'd0, 128'h70);
    fork
      begin send(3'd1, 128'h71); send(3'd2, 128'h72); end
      ack(1, 0, 0, 32'h70, 16'h70);
    join
    ack(0, 0, 0, 32'h71, 16'h71); ack(0, 0, 0, 32'h72, 16'h72);
    cyc(3);

    // Flush with three in flight
    I_RSP_READY = 0;
    send(3'd0, 128'h80); send(3'd0, 128'h81); send(3'd0, 128'h82);
    ack(1, 0, 0, 32'h80, 16'h80); ack(0, 0, 0, 32'h81, 16'h81); ack(1, 0, 0, 32'h82, 16'h82);
    I_FLUSH = 1; cyc(1); I_FLUSH = 0;
    #1;
    chk("t5_ready_drain", {O_REQ_READY, O_INFLIGHT}, {1'b0, 7'd3});
    I_RSP_READY = 1;
    cyc(2);
    chk("t5_no_done_early", O_FLUSH_DONE, 1'b0);
    cyc(1);
    chk("t5_flush_done", {O_FLUSH_DONE, O_INFLIGHT}, {1'b1, 7'd0});
    cyc(1);
    chk("t5_done_pulse", O_FLUSH_DONE, 1'b0);

    // Reset mid-operation and a stray ACK
    send(3'd0, 128'h90);
    I_RST = 1; cyc(1); I_RST = 0;
    chk("t6_reset_clears", {O_INFLIGHT, O_CMD_VALID}, 8'd0);
    ack(1, 0, 0, 32'h90, 16'h90);
    chk("t6_proto_err", {O_PROTO_ERR, O_RSP_VALID}, 2'b10);
    cyc(2);
    chk("t6_proto_sticky", O_PROTO_ERR, 1'b1);
    I_RST = 1; cyc(1); I_RST = 0;
    chk("t6_proto_cleared", O_PROTO_ERR, 1'b0);
    cyc(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
